// File: rtl/ld_halt_sequencer_pkg.sv
// Shared control-unit definitions for the x=1 opcode block sequencer:
// register indices, opcode field positions, HALT opcode and FSM state type.
package ld_halt_sequencer_pkg;

    localparam int IDX_B  = 0;
    localparam int IDX_C  = 1;
    localparam int IDX_D  = 2;
    localparam int IDX_E  = 3;
    localparam int IDX_H  = 4;
    localparam int IDX_L  = 5;
    localparam int IDX_HL = 6;
    localparam int IDX_A  = 7;

    localparam int OPC_X_MSB = 7;
    localparam int OPC_X_LSB = 6;
    localparam int OPC_Y_MSB = 5;
    localparam int OPC_Y_LSB = 3;
    localparam int OPC_Z_MSB = 2;
    localparam int OPC_Z_LSB = 0;

    localparam logic [1:0] OPC_X_LD = 2'b01;
    localparam logic [7:0] OPC_HALT = 8'h76;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HALTED,
        ST_WAKE
    } seq_state_t;

endpackage

// File: rtl/ld_halt_sequencer_mcycle_counter.sv
// One-hot T-step ring plus M-cycle count. clear loads step 0 / M-cycle 0,
// idle parks both at zero, stall freezes them.
module ld_halt_sequencer_mcycle_counter #(
    parameter int STEPS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             idle,
    input  logic             stall,
    output logic [STEPS-1:0] step,
    output logic [1:0]       mcycle
);

    localparam logic [STEPS-1:0] STEP_FIRST = STEPS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step   <= '0;
            mcycle <= 2'd0;
        end else if (clear) begin
            step   <= STEP_FIRST;
            mcycle <= 2'd0;
        end else if (idle) begin
            step   <= '0;
            mcycle <= 2'd0;
        end else if (!stall) begin
            step <= {step[STEPS-2:0], step[STEPS-1]};
            if (step[STEPS-1]) begin
                mcycle <= mcycle + 2'd1;
            end
        end
    end

endmodule

// File: rtl/ld_halt_sequencer.sv
// Self-timed sequencer for LD r,r' / LD r,(HL) / LD (HL),r / HALT with
// interrupt wake. Optional HALT bug behaviour is enabled by HALT_BUG_EN.
module ld_halt_sequencer
    import ld_halt_sequencer_pkg::*;
#(
    parameter int STEPS = 4,
    parameter int REGS  = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Start,
    input  logic [7:0]       i_Opcode,
    input  logic             i_Int_Pending,
    input  logic             i_IME,
    input  logic             i_Stall,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [STEPS-1:0] o_Step,
    output logic [1:0]       o_Mcycle,
    output logic             o_IR_Fetch,
    output logic [REGS-1:0]  o_Read8,
    output logic [REGS-1:0]  o_Write8,
    output logic             o_Address_HL,
    output logic             o_Bus_In,
    output logic             o_Bus_Out,
    output logic             o_Halted,
    output logic             o_Skip_PC_Inc
);

    localparam logic [REGS-1:0] REG_ONE = REGS'(1);

    seq_state_t   state_reg;
    logic [5:0]   op_reg;
    logic         busy_reg;
    logic         halted_reg;
    logic [STEPS-1:0] step;
    logic [1:0]   mcycle;

    logic [2:0] y_fld, z_fld;
    logic is_halt, is_hl_src, is_hl_dst, is_mem;
    logic st_idle, st_exec, st_halted, st_wake;
    logic m0, at_last, last_m;
    logic exec_end, wake_end, halt_go, done_raw, can_start, wake_go;

    assign y_fld = op_reg[OPC_Y_MSB:OPC_Y_LSB];
    assign z_fld = op_reg[OPC_Z_MSB:OPC_Z_LSB];

    assign is_halt   = ({OPC_X_LD, op_reg} == OPC_HALT);
    assign is_hl_src = (z_fld == 3'(IDX_HL)) && !is_halt;
    assign is_hl_dst = (y_fld == 3'(IDX_HL)) && !is_halt;
    assign is_mem    = is_hl_src || is_hl_dst;

    assign st_idle   = (state_reg == ST_IDLE);
    assign st_exec   = (state_reg == ST_EXEC);
    assign st_halted = (state_reg == ST_HALTED);
    assign st_wake   = (state_reg == ST_WAKE);

    assign m0      = (mcycle == 2'd0);
    assign at_last = step[STEPS-1] && !i_Stall;
    assign last_m  = is_mem ? (mcycle == 2'd1) : m0;

    // HALT always ends M0: either it parks in HALTED or it exits as done.
    assign exec_end  = st_exec && at_last && (is_halt || last_m);
    assign wake_end  = st_wake && at_last;
    assign halt_go   = st_exec && is_halt && at_last && !i_Int_Pending;
    assign done_raw  = (exec_end && !halt_go) || wake_end;
    assign can_start = i_Start && (i_Opcode[OPC_X_MSB:OPC_X_LSB] == OPC_X_LD)
                       && !i_Stall && (st_idle || done_raw);
    assign wake_go   = st_halted && !i_Stall && i_Int_Pending;

    ld_halt_sequencer_mcycle_counter #(
        .STEPS(STEPS)
    ) u_counter (
        .clk    (i_Clk),
        .rst_n  (i_Rst_n),
        .clear  (can_start || wake_go),
        .idle   (st_idle || st_halted || exec_end || wake_end),
        .stall  (i_Stall),
        .step   (step),
        .mcycle (mcycle)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            busy_reg   <= 1'b0;
            halted_reg <= 1'b0;
        end else if (can_start) begin
            state_reg  <= ST_EXEC;
            op_reg     <= i_Opcode[OPC_Y_MSB:OPC_Z_LSB];
            busy_reg   <= 1'b1;
            halted_reg <= 1'b0;
        end else if (halt_go) begin
            state_reg  <= ST_HALTED;
            busy_reg   <= 1'b1;
            halted_reg <= 1'b1;
        end else if (done_raw) begin
            state_reg  <= ST_IDLE;
            busy_reg   <= 1'b0;
            halted_reg <= 1'b0;
        end else if (wake_go) begin
            state_reg  <= ST_WAKE;
            busy_reg   <= 1'b1;
            halted_reg <= 1'b0;
        end
    end

    assign o_Busy       = busy_reg;
    assign o_Halted     = halted_reg;
    assign o_Step       = step;
    assign o_Mcycle     = mcycle;
    assign o_Done       = done_raw;
    assign o_Address_HL = st_exec && is_mem && m0;
    assign o_IR_Fetch   = (st_exec && (is_mem ? (mcycle == 2'd1) : m0)) || st_wake;
    assign o_Bus_In     = st_exec && is_hl_src && m0 && at_last;
    assign o_Bus_Out    = st_exec && is_hl_dst && m0 && at_last;

    // (HL) is a memory operand, never a register-file strobe, so bit 6 stays clear.
    assign o_Read8  = (st_exec && m0 && step[1] && !i_Stall && !is_hl_src && !is_halt)
                      ? (REG_ONE << z_fld) : '0;
    assign o_Write8 = (st_exec && m0 && step[STEPS-1] && !i_Stall && !is_hl_dst && !is_halt)
                      ? (REG_ONE << y_fld) : '0;

`ifdef HALT_BUG_EN
    assign o_Skip_PC_Inc = exec_end && is_halt && i_Int_Pending && !i_IME;
`else
    logic ime_unused;
    assign ime_unused    = i_IME;
    assign o_Skip_PC_Inc = 1'b0;
`endif

endmodule

// File: doc/ld_halt_sequencer.md
# ld_halt_sequencer

Self-timed execution sequencer for the x=1 opcode block (LD r,r' / LD r,(HL) / LD (HL),r / HALT) in the control unit. It owns its own T-step and M-cycle counters rather than consuming them from the central timing logic. It adds a HALT state machine with interrupt wake, a stall input, and width parameters for step count and register select. The control-unit dispatcher starts it on an x=1 opcode; the register file, address mux and bus interface consume its strobes.

## Interface
- STEPS, 4: T-steps per M-cycle (≥3); o_Step is one-hot of this width.
- REGS, 8: register-select width; index = opcode y/z field (B,C,D,E,H,L,(HL),A).
- i_Clk  in  1  rising-edge clock.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Start  in  1  one-cycle pulse with i_Opcode valid; ignored while o_Busy or if i_Opcode[7:6]≠2'b01.
- i_Opcode  in  8  opcode; y=[5:3] destination, z=[2:0] source; latched on accepted i_Start.
- i_Int_Pending  in  1  (IE & IF) non-zero.
- i_IME  in  1  interrupt master enable.
- i_Stall  in  1  freezes counters, state and all strobes for that cycle.
- o_Busy  out  1  instruction in progress (includes HALTED).
- o_Done  out  1  one-cycle pulse on the last step of the last M-cycle.
- o_Step  out  STEPS  one-hot current T-step; all-zero when idle.
- o_Mcycle  out  2  current M-cycle index.
- o_IR_Fetch  out  1  next-opcode fetch M-cycle active.
- o_Read8  out  REGS  one-hot source register read; bit 6 never set.
- o_Write8  out  REGS  one-hot destination register write; bit 6 never set.
- o_Address_HL  out  1  drive HL onto the address bus.
- o_Bus_In / o_Bus_Out  out  1  memory read / write data strobe.
- o_Halted  out  1  CPU is in HALT low-power state.
- o_Skip_PC_Inc  out  1  HALT-bug pulse (see Configuration).

## Operation
- FSM states: IDLE, EXEC, HALTED, WAKE. Reset forces IDLE, counters to zero, and every output to 0.
- IDLE → EXEC on an accepted i_Start. The step counter starts at step 0 the following cycle.
- Reg-reg (y≠6, z≠6): 1 M-cycle, o_IR_Fetch for the whole M-cycle. o_Read8[z] at step 1; o_Write8[y] at step STEPS-1; o_Done at step STEPS-1.
- LD r,(HL) (z=6): M0 o_Address_HL all steps. o_Bus_In and o_Write8[y] at step STEPS-1. M1 is the o_IR_Fetch cycle; o_Done at M1 step STEPS-1.
- LD (HL),r (y=6): as above, but o_Read8[z] at step 1 of M0 and o_Bus_Out at step STEPS-1 of M0.
- HALT (0x76), M0 step STEPS-1:
  - i_Int_Pending=0 → HALTED.
  - i_Int_Pending=1 → o_Done and return to IDLE with no halt.
- HALTED: o_Halted=1, o_Step held at 0, no strobes. i_Int_Pending=1 sampled → WAKE the next cycle; i_IME is irrelevant to wake.
- WAKE: one M-cycle with o_IR_Fetch, then o_Done → IDLE.
- i_Stall=1: no state change, all single-step strobes (Read8/Write8/Bus/Done) are forced to 0. o_Halted, o_Address_HL and o_IR_Fetch hold.
- i_Start during o_Done cycle is accepted (back-to-back); next instruction's step 0 follows immediately.

## Timing
- Latency start→first step: 1 cycle.
- Instruction length: STEPS cycles (reg-reg), 2·STEPS cycles ((HL) forms, HALT-not-taken exit STEPS), plus stall cycles.
- Wake latency: i_Int_Pending high → WAKE step 0 next cycle; o_Done STEPS cycles later.
- Async reset mid-instruction: outputs clear immediately, no partial strobe after deassertion.
- o_Mcycle wraps only via return to IDLE; max value 1.

## Configuration
- HALT_BUG_EN defined: HALT with i_Int_Pending=1 and i_IME=0 pulses o_Skip_PC_Inc with o_Done and does not halt.
- HALT_BUG_EN undefined: o_Skip_PC_Inc is tied to 0; that case behaves like any HALT-not-taken exit.

## Structure
- Shared control-unit package:
  - register index constants (IDX_B=0 … IDX_HL=6, IDX_A=7)
  - opcode field positions
  - OPC_HALT=8'h76
  - state enum
- Sub-module mcycle_counter: one-hot step ring plus M-cycle count, with clear/stall/enable.

## Test plan
- 0x41 (LD B,C), STEPS=4: o_Read8=8'h02 at step 1; o_Write8=8'h01 at step 3; o_Done 4 cycles after start.
- 0x7E (LD A,(HL)): o_Address_HL for 4 cycles; o_Bus_In and o_Write8=8'h80 at M0 step 3; o_IR_Fetch in M1; o_Done at cycle 8.
- 0x72 (LD (HL),D): o_Read8=8'h04 at M0 step 1; o_Bus_Out at M0 step 3; bit 6 never set on Read8/Write8.
- 0x76 with no interrupt: o_Halted held 20 cycles. Raise i_Int_Pending → WAKE with o_IR_Fetch; o_Done 4 cycles later; o_Halted drops.
- 0x76 with i_Int_Pending=1, i_IME=0: with HALT_BUG_EN, o_Skip_PC_Inc=1 with o_Done and no halt; without it, 0.
- i_Stall 3 cycles at step 2 of 0x41 → o_Done delayed 3 cycles. i_Rst_n low at step 2 → all outputs 0 at once, IDLE after release.
